alu_cmd_sequencer: RTL and testbench

Initiator-side driver for the registered 4-bit ALU wrapper. It accepts ALU commands (a, b, op) on a valid/ready interface and drives them onto the wrapper's operand/opcode inputs. After the wrapper's fixed pipeline latency it captures result/carry. Responses are returned in order through a small response FIFO with valid/ready backpressure. Credit accounting guarantees no response is ever dropped.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_cmd_sequencer_if.sv | 30 +++
 rtl/alu_rsp_fifo.sv | 70 +++++++
 rtl/alu_cmd_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode encodings and the response word layout
// for the ALU command sequencer and its response FIFO.
//   DW          operand/result width
//   OPW         opcode width
//   LAT_DEFAULT wrapper latency (alu_* change to alu_result valid, in edges)
//   RSP_W       packed response word width (result, carry, opcode)
package alu_pkg;

  localparam int DW          = 4;
  localparam int OPW         = 3;
  localparam int LAT_DEFAULT = 2;
  localparam int RSP_W       = DW + 1 + OPW;

  // Opcode encodings; remaining codes are reserved and passed through untouched.
  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;

  typedef struct packed {
    logic [DW-1:0]  result;
    logic           carry;
    logic [OPW-1:0] op;
  } rsp_word_t;

  function automatic rsp_word_t pack_rsp(input logic [DW-1:0] result,
                                         input logic carry,
                                         input logic [OPW-1:0] op);
    rsp_word_t w;
    w.result = result;
    w.carry  = carry;
    w.op     = op;
    return w;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and response handshakes of the sequencer.
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op          command channel
//   rsp_valid/rsp_ready/rsp_result/rsp_carry/rsp_op response channel
// master = command issuer / response consumer, slave = the sequencer.
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [DW-1:0]  cmd_a;
  logic [DW-1:0]  cmd_b;
  logic [OPW-1:0] cmd_op;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_result;
  logic           rsp_carry;
  logic [OPW-1:0] rsp_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_op
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous FIFO with registered wrap-bit pointers.
//   clk, rst     clock, async active-high reset (empties FIFO, clears storage)
//   push, din    write request and data
//   pop          read request (advances head)
//   full, empty  occupancy flags
//   head         current head word
// alu_rsp_fifo_chk: simulation checker flagging overflow and underflow.
module alu_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop & ~empty;
  // A write into a full FIFO is allowed only when the head leaves on the same edge.
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

module alu_rsp_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives commands into a registered ALU wrapper and
// returns results in order through a credit-protected response FIFO.
//   clk, rst                  clock, async active-high reset
//   io (slave)                command and response handshakes
//   alu_a, alu_b, alu_op      registered operands/opcode to the wrapper
//   alu_result, alu_carry     wrapper outputs, valid LAT edges after alu_* change
//   busy                      at least one command outstanding
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  io,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [OPW-1:0]      alu_op,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_carry,
  output logic                busy
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 accept_s;
  logic                 pop_s;
  logic                 ready_r;
  logic [CNT_W-1:0]     outstanding_r;
  logic [CNT_W-1:0]     outstanding_nxt_s;
  logic [LAT:0]         pend_v_r;
  logic [OPW-1:0]       pend_op_r [LAT+1];
  rsp_word_t            push_word_s;
  logic [RSP_W-1:0]     head_bits_s;
  rsp_word_t            head_s;
  logic                 full_s;
  logic                 empty_s;

  // Ready comes from registered credit state only; reset masks it directly.
  assign io.cmd_ready = ~rst & ready_r;
  assign accept_s     = io.cmd_valid & io.cmd_ready;
  assign pop_s        = io.rsp_valid & io.rsp_ready;

  assign io.rsp_valid  = ~empty_s;
  assign head_s        = rsp_word_t'(head_bits_s);
  assign io.rsp_result = head_s.result;
  assign io.rsp_carry  = head_s.carry;
  assign io.rsp_op     = head_s.op;

  // Operand registers toward the wrapper; they hold between accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept_s) begin
      alu_a  <= io.cmd_a;
      alu_b  <= io.cmd_b;
      alu_op <= io.cmd_op;
    end
  end

  // Pending tracker: stage LAT marks the edge on which the wrapper output is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_r <= '0;
      for (int i = 0; i <= LAT; i++) begin
        pend_op_r[i] <= '0;
      end
    end else begin
      pend_v_r     <= {pend_v_r[LAT-1:0], accept_s};
      pend_op_r[0] <= accept_s ? io.cmd_op : {OPW{1'b0}};
      for (int i = 1; i <= LAT; i++) begin
        pend_op_r[i] <= pend_op_r[i-1];
      end
    end
  end

  // Credit counter next value: accept and pop on the same edge cancel.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    case ({accept_s, pop_s})
      2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // Credit state plus registered ready/busy derived from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= '0;
      ready_r       <= 1'b1;
      busy          <= 1'b0;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      ready_r       <= (outstanding_nxt_s < CNT_MAX);
      busy          <= (outstanding_nxt_s != '0);
    end
  end

  // Captured wrapper output tagged with the opcode that produced it.
  always_comb begin
    push_word_s = pack_rsp(alu_result, alu_carry, pend_op_r[LAT]);
  end

  alu_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_v_r[LAT]),
    .pop   (pop_s),
    .din   (push_word_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_bits_s)
  );

  alu_rsp_fifo_chk u_rsp_fifo_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_v_r[LAT]),
    .pop   (pop_s),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed self-checking bench for alu_cmd_sequencer.
// Includes a two-stage registered ALU wrapper model feeding alu_result/alu_carry.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_result;
  logic           alu_carry;
  logic           busy;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.LAT(2), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Wrapper model: carry is bit 4 of the 5-bit result (borrow for SUB).
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      OP_ADD:  alu_f = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_f = {1'b0, a} - {1'b0, b};
      OP_AND:  alu_f = {1'b0, a & b};
      OP_OR:   alu_f = {1'b0, a | b};
      OP_XOR:  alu_f = {1'b0, a ^ b};
      default: alu_f = 5'd0;
    endcase
  endfunction

  logic [4:0] s1_r;
  logic [4:0] s2_r;
  logic       tog_en  = 1'b0;
  logic [4:0] tog_val = 5'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 5'd0;
      s2_r <= 5'd0;
    end else begin
      s1_r <= alu_f(alu_a, alu_b, alu_op);
      s2_r <= s1_r;
    end
  end

  assign alu_result = tog_en ? tog_val[3:0] : s2_r[3:0];
  assign alu_carry  = tog_en ? tog_val[4]   : s2_r[4];

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic [2:0] op;
    int         cyc;
  } rsp_log_t;

  rsp_log_t rq[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Log the handshakes that will occur at the coming rising edge, then advance.
  task automatic tick();
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1)
      rq.push_back('{res: bus.rsp_result, c: bus.rsp_carry, op: bus.rsp_op, cyc: cyc});
    if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1)
      n_acc++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.cmd_a  = a;
    bus.cmd_b  = b;
    bus.cmd_op = op;
  endtask

  task automatic drain(input int want);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 30 && rq.size() < want; k++) tick();
    bus.rsp_ready = 1'b0;
    check_eq("drain_count", 32'(rq.size()), 32'(want));
  endtask

  logic [3:0] t3_a  [4] = '{4'd9, 4'd2, 4'd12, 4'd15};
  logic [3:0] t3_b  [4] = '{4'd9, 4'd1, 4'd10, 4'd15};
  logic [2:0] t3_op [4] = '{OP_ADD, OP_SUB, OP_AND, OP_XOR};
  logic [3:0] t3_r  [4] = '{4'd2, 4'd1, 4'd8, 4'd0};
  logic       t3_c  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic [3:0] t4_a  [6] = '{4'd1, 4'd15, 4'd5, 4'd0, 4'd6, 4'd7};
  logic [3:0] t4_b  [6] = '{4'd2, 4'd1, 4'd10, 4'd1, 4'd3, 4'd7};
  logic [2:0] t4_op [6] = '{OP_ADD, OP_ADD, OP_OR, OP_SUB, OP_XOR, OP_AND};
  logic [3:0] t4_r  [5] = '{4'd3, 4'd0, 4'd15, 4'd15, 4'd5};
  logic       t4_c  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic [3:0] t5_r  [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    set_cmd(4'd0, 4'd0, OP_ADD);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1. reset state
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_busy",      32'(busy),          32'd0);
    check_eq("rst_alu_a",     32'(alu_a),         32'd0);
    check_eq("rst_alu_b",     32'(alu_b),         32'd0);
    check_eq("rst_alu_op",    32'(alu_op),        32'd0);
    check_eq("rst_rsp_res",   32'(bus.rsp_result), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 2. single command, latency LAT+1
    set_cmd(4'd3, 4'd5, OP_ADD);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("t2_alu_a",   32'(alu_a),  32'd3);
    check_eq("t2_alu_b",   32'(alu_b),  32'd5);
    check_eq("t2_alu_op",  32'(alu_op), 32'd0);
    check_eq("t2_busy",    32'(busy),   32'd1);
    tick();
    tick();
    check_eq("t2_early_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_eq("t2_rsp_valid",  32'(bus.rsp_valid),  32'd1);
    check_eq("t2_rsp_result", 32'(bus.rsp_result), 32'd8);
    check_eq("t2_rsp_carry",  32'(bus.rsp_carry),  32'd0);
    check_eq("t2_rsp_op",     32'(bus.rsp_op),     32'd0);
    check_eq("t2_busy_held",  32'(busy),           32'd1);
    check_eq("t2_alu_a_hold", 32'(alu_a),          32'd3);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("t2_popped",     32'(bus.rsp_valid), 32'd0);
    check_eq("t2_busy_clear", 32'(busy),          32'd0);
    rq.delete();

    // 3. streaming with rsp_ready held high
    bus.rsp_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(t3_a[i], t3_b[i], t3_op[i]);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 12 && rq.size() < 4; k++) tick();
    check_eq("t3_accepts", 32'(n_acc), 32'd4);
    check_eq("t3_rsp_count", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rq.size()) begin
        check_eq($sformatf("t3_res%0d", i), 32'(rq[i].res), 32'(t3_r[i]));
        check_eq($sformatf("t3_c%0d", i),   32'(rq[i].c),   32'(t3_c[i]));
        check_eq($sformatf("t3_op%0d", i),  32'(rq[i].op),  32'(t3_op[i]));
        if (i > 0) check_eq($sformatf("t3_gap%0d", i), 32'(rq[i].cyc - rq[i-1].cyc), 32'd1);
      end
    end
    bus.rsp_ready = 1'b0;
    check_eq("t3_busy_end", 32'(busy), 32'd0);
    rq.delete();

    // 4. backpressure: credits cap accepts at DEPTH
    n_acc = 0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_cmd(t4_a[n_acc], t4_b[n_acc], t4_op[n_acc]);
      tick();
    end
    check_eq("t4_accepts_full", 32'(n_acc),          32'd4);
    check_eq("t4_ready_low",    32'(bus.cmd_ready),  32'd0);
    check_eq("t4_rsp_valid",    32'(bus.rsp_valid),  32'd1);
    check_eq("t4_busy",         32'(busy),           32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("t4_one_pop",      32'(rq.size()),      32'd1);
    check_eq("t4_ready_after",  32'(bus.cmd_ready),  32'd1);
    set_cmd(t4_a[4], t4_b[4], t4_op[4]);
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("t4_fifth_acc",    32'(n_acc),          32'd5);
    check_eq("t4_ready_again",  32'(bus.cmd_ready),  32'd0);
    drain(5);
    for (int i = 0; i < 5; i++) begin
      if (i < rq.size()) begin
        check_eq($sformatf("t4_res%0d", i), 32'(rq[i].res), 32'(t4_r[i]));
        check_eq($sformatf("t4_c%0d", i),   32'(rq[i].c),   32'(t4_c[i]));
        check_eq($sformatf("t4_op%0d", i),  32'(rq[i].op),  32'(t4_op[i]));
      end
    end
    check_eq("t4_busy_end", 32'(busy), 32'd0);
    rq.delete();

    // 5. accept and pop on the same edge with 3 outstanding
    n_acc = 0;
    for (int i = 1; i <= 3; i++) begin
      set_cmd(4'(i), 4'(i), OP_ADD);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    check_eq("t5_ready_pre", 32'(bus.cmd_ready), 32'd1);
    check_eq("t5_valid_pre", 32'(bus.rsp_valid), 32'd1);
    set_cmd(4'd4, 4'd4, OP_ADD);
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check_eq("t5_both_acc",   32'(n_acc),         32'd4);
    check_eq("t5_both_pop",   32'(rq.size()),     32'd1);
    check_eq("t5_ready_hold", 32'(bus.cmd_ready), 32'd1);
    check_eq("t5_busy",       32'(busy),          32'd1);
    set_cmd(4'd5, 4'd5, OP_ADD);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("t5_acc_to_full", 32'(n_acc),         32'd5);
    check_eq("t5_count_was_3", 32'(bus.cmd_ready), 32'd0);
    drain(5);
    for (int i = 0; i < 5; i++) begin
      if (i < rq.size()) begin
        check_eq($sformatf("t5_res%0d", i), 32'(rq[i].res), 32'(t5_r[i]));
        check_eq($sformatf("t5_c%0d", i),   32'(rq[i].c),   32'd0);
      end
    end
    rq.delete();

    // 6. reset with 3 in flight and 1 queued
    for (int i = 0; i < 4; i++) begin
      set_cmd(4'(2 * i + 1), 4'(2 * i + 2), OP_ADD);
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check_eq("t6_pre_queued", 32'(bus.rsp_valid), 32'd1);
    check_eq("t6_pre_busy",   32'(busy),          32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("t6_rst_busy",  32'(busy),          32'd0);
    check_eq("t6_rst_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tog_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tog_val = 5'($urandom_range(0, 31));
      tick();
      check_eq($sformatf("t6_no_stale%0d", k), 32'(bus.rsp_valid), 32'd0);
    end
    tog_en = 1'b0;
    check_eq("t6_busy_after",  32'(busy),          32'd0);
    check_eq("t6_ready_after", 32'(bus.cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
